// File: rtl/mem_wait_ctrl.sv
// ============================================================================
// Module      : mem_wait_ctrl
// Description : GBA wait-state generator. Decodes the region of each bus
//               access, classifies it N/S and stalls the bus master for the
//               WAITCNT-derived number of wait cycles.
//               Optional stall statistics: define MEM_WAIT_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_ctrl #(
    parameter int ROM_PAGE_BITS = 17,
    parameter int EWRAM_WAIT    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        write,
    input  logic [15:0] waitcnt,
    output logic        pause,
    output logic        done,
    output logic        seq,
    output logic [3:0]  region
`ifdef MEM_WAIT_STATS_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [4:0] c_EWRAM_HALF = 5'(EWRAM_WAIT);

    localparam logic [3:0] c_RGN_EWRAM = 4'h2;
    localparam logic [3:0] c_RGN_PAL   = 4'h5;
    localparam logic [3:0] c_RGN_VRAM  = 4'h6;
    localparam logic [3:0] c_RGN_WS0A  = 4'h8;
    localparam logic [3:0] c_RGN_WS0B  = 4'h9;
    localparam logic [3:0] c_RGN_WS1A  = 4'hA;
    localparam logic [3:0] c_RGN_WS1B  = 4'hB;
    localparam logic [3:0] c_RGN_WS2A  = 4'hC;
    localparam logic [3:0] c_RGN_WS2B  = 4'hD;
    localparam logic [3:0] c_RGN_SRMA  = 4'hE;
    localparam logic [3:0] c_RGN_SRMB  = 4'hF;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [4:0]  r_cnt;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [3:0]  r_region;
    logic        r_seq;

    logic        r_hist_valid;
    logic [31:0] r_prev_addr;
    logic [1:0]  r_prev_size;
    logic [3:0]  r_prev_region;

    logic [3:0]  w_rgn;
    logic        w_word;
    logic        w_page_start;
    logic        w_is_sram;
    logic        w_seq_hit;
    logic [4:0]  w_n_wait;
    logic [4:0]  w_s_wait;
    logic        w_is_rom;
    logic [4:0]  w_total;
    logic        w_start;
    logic        w_load;
    logic [31:0] w_cur_addr;
    logic [1:0]  w_cur_size;
    logic [3:0]  w_cur_region;

    // Write direction and the upper address nibble do not affect timing.
    logic        w_unused;
    assign w_unused = ^{write, addr[31:28], waitcnt[15:11]};

    function automatic logic [4:0] f_n_wait(input logic [1:0] field);
        case (field)
            2'd0:    f_n_wait = 5'd4;
            2'd1:    f_n_wait = 5'd3;
            2'd2:    f_n_wait = 5'd2;
            default: f_n_wait = 5'd8;
        endcase
    endfunction

    assign w_rgn        = addr[27:24];
    assign w_word       = size[1];
    assign w_page_start = (addr[ROM_PAGE_BITS-1:0] == '0);
    assign w_is_sram    = (w_rgn == c_RGN_SRMA) || (w_rgn == c_RGN_SRMB);

    // Sequential only when the previous access finished last cycle and this
    // one continues it contiguously inside the same region and ROM page.
    assign w_seq_hit = r_hist_valid
                    && (r_prev_region == w_rgn)
                    && (addr == r_prev_addr + (32'd1 << r_prev_size))
                    && !w_page_start
                    && !w_is_sram;

    always_comb begin
        w_n_wait = 5'd0;
        w_s_wait = 5'd0;
        w_is_rom = 1'b0;
        w_total  = 5'd0;
        case (w_rgn)
            c_RGN_WS0A, c_RGN_WS0B: begin
                w_is_rom = 1'b1;
                w_n_wait = f_n_wait(waitcnt[3:2]);
                w_s_wait = waitcnt[4] ? 5'd1 : 5'd2;
            end
            c_RGN_WS1A, c_RGN_WS1B: begin
                w_is_rom = 1'b1;
                w_n_wait = f_n_wait(waitcnt[6:5]);
                w_s_wait = waitcnt[7] ? 5'd1 : 5'd4;
            end
            c_RGN_WS2A, c_RGN_WS2B: begin
                w_is_rom = 1'b1;
                w_n_wait = f_n_wait(waitcnt[9:8]);
                w_s_wait = waitcnt[10] ? 5'd1 : 5'd8;
            end
            default: ;
        endcase

        if (w_is_rom) begin
            // The second half of a split word always follows the first.
            w_total = (w_seq_hit ? w_s_wait : w_n_wait)
                    + (w_word ? w_s_wait : 5'd0);
        end else if (w_is_sram) begin
            w_total = f_n_wait(waitcnt[1:0]);
        end else if (w_rgn == c_RGN_EWRAM) begin
            w_total = w_word ? (c_EWRAM_HALF + c_EWRAM_HALF) : c_EWRAM_HALF;
        end else if ((w_rgn == c_RGN_PAL) || (w_rgn == c_RGN_VRAM)) begin
            w_total = w_word ? 5'd1 : 5'd0;
        end
    end

    assign w_start = (r_state == S_IDLE) && valid && !reset;
    assign w_load  = w_start && (w_total != 5'd0);

    always_comb begin
        w_next_state = r_state;
        pause        = 1'b0;
        done         = 1'b0;
        seq          = 1'b0;
        region       = 4'h0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    region = w_rgn;
                    seq    = w_seq_hit;
                    if (w_total == 5'd0) begin
                        done = 1'b1;
                    end else begin
                        pause        = 1'b1;
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                region = r_region;
                seq    = r_seq;
                if (r_cnt == 5'd0) begin
                    done         = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    pause = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Completed-access identity for the sequential history.
    assign w_cur_addr   = (r_state == S_IDLE) ? addr  : r_addr;
    assign w_cur_size   = (r_state == S_IDLE) ? size  : r_size;
    assign w_cur_region = (r_state == S_IDLE) ? w_rgn : r_region;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 5'd0;
            r_addr        <= 32'd0;
            r_size        <= 2'd0;
            r_region      <= 4'h0;
            r_seq         <= 1'b0;
            r_hist_valid  <= 1'b0;
            r_prev_addr   <= 32'd0;
            r_prev_size   <= 2'd0;
            r_prev_region <= 4'h0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_cnt    <= w_total - 5'd1;
                r_addr   <= addr;
                r_size   <= size;
                r_region <= w_rgn;
                r_seq    <= w_seq_hit;
            end else if ((r_state == S_WAIT) && (r_cnt != 5'd0)) begin
                r_cnt <= r_cnt - 5'd1;
            end

            // History lives for exactly one cycle after a completion.
            r_hist_valid <= done;
            if (done) begin
                r_prev_addr   <= w_cur_addr;
                r_prev_size   <= w_cur_size;
                r_prev_region <= w_cur_region;
            end
        end
    end

`ifdef MEM_WAIT_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
        end else if (pause) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wait_ctrl.sv
// ============================================================================
// Module      : tb_mem_wait_ctrl
// Description : Directed self-checking bench for mem_wait_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wait_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        write;
    logic [15:0] waitcnt;
    logic        pause;
    logic        done;
    logic        seq;
    logic [3:0]  region;
`ifdef MEM_WAIT_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int checks    = 0;
    int failures  = 0;
    int exp_stall = 0;

    always #5 clock = ~clock;

    mem_wait_ctrl #(
        .ROM_PAGE_BITS(17),
        .EWRAM_WAIT   (2)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .valid  (valid),
        .addr   (addr),
        .size   (size),
        .write  (write),
        .waitcnt(waitcnt),
        .pause  (pause),
        .done   (done),
        .seq    (seq),
        .region (region)
`ifdef MEM_WAIT_STATS_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    // One access: presented for a cycle, then the bus is scrambled while the
    // controller counts down; pause/done/seq/region checked every cycle.
    task automatic access(input logic [31:0] a, input logic [1:0] sz,
                          input logic [15:0] wc, input int w,
                          input logic s, input string name);
        logic [3:0] exp_rgn;
        exp_rgn = a[27:24];
        @(posedge clock); #1;
        valid = 1'b1; addr = a; size = sz; waitcnt = wc; write = 1'b0;
        @(negedge clock);
        checks++;
        if ({pause, done, seq, region} !== {(w != 0), (w == 0), s, exp_rgn}) begin
            failures++;
            $display("FAIL %s cycle0: pause=%b done=%b seq=%b region=%h, expected pause=%b done=%b seq=%b region=%h",
                     name, pause, done, seq, region, (w != 0), (w == 0), s, exp_rgn);
        end
        exp_stall += w;
        for (int k = 1; k <= w; k++) begin
            @(posedge clock); #1;
            addr = 32'h0300_0000; size = 2'd0; waitcnt = 16'hFFFF; write = 1'b1;
            @(negedge clock);
            checks++;
            if ({pause, done, seq, region} !== {(k < w), (k == w), s, exp_rgn}) begin
                failures++;
                $display("FAIL %s cycle%0d: pause=%b done=%b seq=%b region=%h, expected pause=%b done=%b seq=%b region=%h",
                         name, k, pause, done, seq, region, (k < w), (k == w), s, exp_rgn);
            end
        end
    endtask

    task automatic idle_cycle(input string name);
        @(posedge clock); #1;
        valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({pause, done} !== 2'b00) begin
            failures++;
            $display("FAIL %s idle: pause=%b done=%b, expected 0 0", name, pause, done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; valid = 1'b0; addr = 32'd0; size = 2'd0;
        write = 1'b0; waitcnt = 16'd0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        checks++;
        if ({pause, done, seq, region} !== 7'd0) begin
            failures++;
            $display("FAIL reset_state: pause=%b done=%b seq=%b region=%h, expected all 0",
                     pause, done, seq, region);
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_ewram_reset;
        idle_cycle("ewram_pre");
        @(posedge clock); #1;
        valid = 1'b1; addr = 32'h0200_0000; size = 2'd2; waitcnt = 16'd0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            checks++;
            if ({pause, done, region} !== {1'b1, 1'b0, 4'h2}) begin
                failures++;
                $display("FAIL ewram_wait%0d: pause=%b done=%b region=%h, expected 1 0 2",
                         k, pause, done, region);
            end
            @(posedge clock); #1;
            valid = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_stall = 0;
        for (int k = 3; k <= 5; k++) begin
            @(negedge clock);
            checks++;
            if ({pause, done} !== 2'b00) begin
                failures++;
                $display("FAIL ewram_after_reset T+%0d: pause=%b done=%b, expected 0 0",
                         k, pause, done);
            end
            @(posedge clock); #1;
        end
`ifdef MEM_WAIT_STATS_EN
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL stats_cleared: stall_cycles=%0d, expected 0", stall_cycles);
        end
`endif
    endtask

    task automatic test_zero_wait;
        access(32'h0300_0000, 2'd2, 16'h0000, 0, 1'b0, "iwram_word");
        access(32'h0500_0000, 2'd2, 16'h0000, 1, 1'b0, "pal_word");
        idle_cycle("zw_gap");
        access(32'h0600_0000, 2'd1, 16'h0000, 0, 1'b0, "vram_half");
        access(32'h0000_0010, 2'd0, 16'h0000, 0, 1'b0, "bios_byte");
    endtask

    task automatic test_rom_seq;
        idle_cycle("rom_gap");
        access(32'h0800_0000, 2'd2, 16'h0000, 6, 1'b0, "ws0_word_n");
        access(32'h0800_0004, 2'd2, 16'h0000, 4, 1'b1, "ws0_word_s");
        idle_cycle("ws0h_gap");
        access(32'h0800_0010, 2'd1, 16'h0014, 3, 1'b0, "ws0_half_n");
        access(32'h0800_0012, 2'd1, 16'h0014, 1, 1'b1, "ws0_half_s");
    endtask

    task automatic test_page_cross;
        idle_cycle("page_gap");
        access(32'h0801_FFFE, 2'd1, 16'h0014, 3, 1'b0, "page_last");
        access(32'h0802_0000, 2'd1, 16'h0014, 3, 1'b0, "page_cross");
        idle_cycle("expire_gap");
        access(32'h0802_0002, 2'd1, 16'h0014, 3, 1'b0, "hist_expired");
    endtask

    task automatic test_other_regions;
        idle_cycle("ws1_gap");
        access(32'h0A00_0000, 2'd2, 16'h00C0, 3, 1'b0, "ws1_word_n");
        access(32'h0A00_0004, 2'd2, 16'h00C0, 2, 1'b1, "ws1_word_s");
        idle_cycle("sram_gap");
        access(32'h0E00_0000, 2'd0, 16'h0003, 8, 1'b0, "sram_byte");
        access(32'h0E00_0001, 2'd0, 16'h0003, 8, 1'b0, "sram_always_n");
        idle_cycle("ws2_gap");
        access(32'h0C00_0000, 2'd2, 16'h0300, 16, 1'b0, "ws2_max");
    endtask

    initial begin
        test_reset();
        test_ewram_reset();
        test_zero_wait();
        test_rom_seq();
        test_page_cross();
        test_other_regions();
        idle_cycle("final");
`ifdef MEM_WAIT_STATS_EN
        checks++;
        if (stall_cycles !== 32'(exp_stall)) begin
            failures++;
            $display("FAIL stats_total: stall_cycles=%0d, expected %0d", stall_cycles, exp_stall);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
